// File: rtl/wave_meter.sv
// Hysteresis slicer plus single-shot period/high-time meter for an 8-bit waveform.
// Define WAVE_METER_DUTY_PCT_EN to add the sequential duty-percent divider.
module wave_meter #(
    parameter int unsigned CNT_W       = 20,
    parameter logic [7:0]  TH_HI       = 8'd160,
    parameter logic [7:0]  TH_LO       = 8'd96,
    parameter int unsigned TIMEOUT_CYC = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       samp,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic [6:0]       duty_pct,
    output logic             level
);

    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE, DIV} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state, state_nx;
    logic [7:0]       s_q;
    logic             lvl, lvl_d;
    logic             rise, fall;
    logic [CNT_W-1:0] pcnt, hcnt, wd;
    logic [CNT_W-1:0] pcnt_inc, hcnt_inc;
    logic             accept, measuring, expire, fire_ok, fire_to;
    logic             div_last;

    // Slicer: level only moves when the sample leaves the hysteresis band.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q   <= '0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            s_q   <= samp;
            lvl_d <= lvl;
            if (s_q >= TH_HI)
                lvl <= 1'b1;
            else if (s_q <= TH_LO)
                lvl <= 1'b0;
        end
    end

    assign rise  = lvl & ~lvl_d;
    assign fall  = ~lvl & lvl_d;
    assign level = lvl;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = ARM;
            ARM:  if (expire) state_nx = IDLE; else if (rise) state_nx = HIGH;
            HIGH: if (expire) state_nx = IDLE; else if (fall) state_nx = LOW;
            LOW:  if (expire) state_nx = IDLE; else if (rise) state_nx = DONE;
`ifdef WAVE_METER_DUTY_PCT_EN
            DONE: state_nx = DIV;
            DIV:  if (div_last) state_nx = IDLE;
`else
            DONE: state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // A start landing on the meas_valid cycle is dropped even if the FSM is already idle.
    always_comb begin
        accept    = (state == IDLE) && start && !meas_valid;
        measuring = (state == ARM) || (state == HIGH) || (state == LOW);
        expire    = measuring && !(rise || fall) && (wd == WD_LAST);
        fire_to   = expire;
`ifdef WAVE_METER_DUTY_PCT_EN
        fire_ok   = (state == DIV) && div_last;
`else
        fire_ok   = (state == LOW) && rise;
`endif
    end

    assign pcnt_inc = (&pcnt) ? pcnt : pcnt + 1'b1;
    assign hcnt_inc = (&hcnt) ? hcnt : hcnt + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
            hcnt <= '0;
            wd   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    pcnt <= '0;
                    hcnt <= '0;
                    wd   <= '0;
                end
                ARM: if (rise) begin
                    pcnt <= CNT_W'(1);
                    hcnt <= CNT_W'(1);
                end
                HIGH: begin
                    pcnt <= pcnt_inc;
                    if (!fall) hcnt <= hcnt_inc;
                end
                LOW: if (!rise) pcnt <= pcnt_inc;
                default: ;
            endcase
            if (measuring)
                wd <= (rise || fall) ? '0 : wd + 1'b1;
        end
    end

`ifdef WAVE_METER_DUTY_PCT_EN
    localparam int unsigned QW = CNT_W + 7;
    localparam int unsigned NW = $clog2(QW + 1);

    logic [QW-1:0]    dvd, q_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic [CNT_W:0]   trial, diff;
    logic [NW-1:0]    div_n;
    logic             ge;

    // Restoring division: dividend shifts out MSB-first, quotient bits shift in.
    always_comb begin
        trial  = {rem, dvd[QW-1]};
        diff   = trial - {1'b0, pcnt};
        ge     = trial >= {1'b0, pcnt};
        rem_nx = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        q_nx   = {dvd[QW-2:0], ge};
    end

    assign div_last = (div_n == NW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dvd   <= '0;
            rem   <= '0;
            div_n <= '0;
        end else if (state == DONE) begin
            dvd   <= QW'(hcnt) * QW'(100);
            rem   <= '0;
            div_n <= NW'(QW);
        end else if (state == DIV) begin
            dvd   <= q_nx;
            rem   <= rem_nx;
            div_n <= div_n - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        duty_pct <= '0;
        else if (fire_to) duty_pct <= '0;
        else if (fire_ok) duty_pct <= q_nx[6:0];
    end
`else
    assign div_last = 1'b0;
    assign duty_pct = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            meas_valid <= fire_ok || fire_to;
            if (accept) begin
                busy    <= 1'b1;
                timeout <= 1'b0;
            end
            if (fire_ok || fire_to)
                busy <= 1'b0;
            if (fire_to) begin
                timeout    <= 1'b1;
                period_cnt <= '0;
                high_cnt   <= '0;
            end else if (fire_ok) begin
                period_cnt <= pcnt;
                high_cnt   <= hcnt;
            end
        end
    end

endmodule
